swipt_demod: RTL and testbench

SWIPT_DEMOD -- requirements
Module: swipt_demod

---
 rtl/swipt_pkg.sv | 27 ++
 rtl/swipt_demod_if.sv | 28 ++
 rtl/swipt_sym_meter.sv | 125 ++++++++++++
 rtl/swipt_demod.sv | 178 +++++++++++++++++
 tb/tb_swipt_demod.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT in-band demodulator.
// Holds the counter width, the default parameter values, the symbol
// classification enum and the frame FSM state enum.
package swipt_pkg;

  localparam int CNT_W = 13;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int MIN_PERIOD_DEF  = 250;
  localparam int SYNC_LONG_DEF   = 4;

  typedef enum logic [1:0] {
    SYM_LONG,
    SYM_SHORT,
    SYM_INV
  } sym_t;

  typedef enum logic [2:0] {
    NOCARRIER,
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/swipt_demod_if.sv
// Signal bundle between the demodulator and its environment.
//   rx_in      : receive-coil comparator output (asynchronous)
//   data_out   : last received byte
//   data_valid : one-cycle pulse when data_out is updated
//   parity_err : one-cycle pulse on a frame with a parity mismatch
//   sym_err    : one-cycle pulse on an invalid symbol / bad stop in a frame
//   carrier_ok : high while the carrier is present
//   period_out : last measured valid symbol period in clk cycles
// master = demodulator side, slave = the side that feeds rx_in.
interface swipt_demod_if;
  logic        rx_in;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        parity_err;
  logic        sym_err;
  logic        carrier_ok;
  logic [12:0] period_out;

  modport master (
    input  rx_in,
    output data_out, data_valid, parity_err, sym_err, carrier_ok, period_out
  );

  modport slave (
    output rx_in,
    input  data_out, data_valid, parity_err, sym_err, carrier_ok, period_out
  );
endinterface

// File: rtl/swipt_sym_meter.sv
// Symbol meter: synchronises rx_in, finds rising edges, measures the period
// and high time of each symbol, classifies it and watches for carrier loss.
//   clk, rst   : clock, asynchronous active-high reset
//   rx_in      : raw comparator output
//   sym_valid  : one-cycle strobe, a classified symbol is presented
//   sym_class  : LONG / SHORT / INVALID
//   sym_period : measured period of the presented symbol
//   first_edge : strobe for the edge that only starts measurement
//   timeout    : strobe when no rising edge was seen for TIMEOUT_CYC cycles
// All outputs are registered one cycle after the edge-detect cycle.
module swipt_sym_meter
  import swipt_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic             sym_valid,
  output sym_t             sym_class,
  output logic [CNT_W-1:0] sym_period,
  output logic             first_edge,
  output logic             timeout
);

  localparam logic [15:0]      MIN_P16  = 16'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic             rx_p0_q, rx_p0_d;
  logic             rx_p1_q, rx_p1_d;
  logic             rx_p2_q, rx_p2_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             armed_q, armed_d;
  logic             sym_valid_q, sym_valid_d;
  sym_t             sym_class_q, sym_class_d;
  logic [CNT_W-1:0] sym_period_q, sym_period_d;
  logic             first_edge_q, first_edge_d;
  logic             timeout_q, timeout_d;
  logic             edge_det;
  logic             tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // 8h and 3p are formed at 16 bits so neither product can wrap.
  function automatic sym_t classify(input logic [CNT_W-1:0] p,
                                    input logic [CNT_W-1:0] h);
    logic [15:0] p16, h8, p3;
    p16 = {3'b000, p};
    h8  = {h, 3'b000};
    p3  = p16 + {p16[14:0], 1'b0};
    if (p == CNT_MAX || h == CNT_MAX || h8 < p16 || p16 < MIN_P16)
      return SYM_INV;
    else if (h8 >= p3)
      return SYM_LONG;
    else
      return SYM_SHORT;
  endfunction

  always_comb begin
    // stage p0/p1: two-flop synchroniser, p2 holds the previous sample
    rx_p0_d  = rx_in;
    rx_p1_d  = rx_p0_q;
    rx_p2_d  = rx_p1_q;
    edge_det = rx_p1_q & ~rx_p2_q;
    tmo_hit  = ~edge_det && (idle_q == TMO_LAST);

    // the edge cycle itself is the first cycle (and first high cycle) of a symbol
    period_d = edge_det ? CNT_W'(1) : sat_inc(period_q);
    high_d   = edge_det ? CNT_W'(1) : (rx_p1_q ? sat_inc(high_q) : high_q);
    idle_d   = edge_det ? '0 : ((idle_q == TMO) ? idle_q : idle_q + 1'b1);

    // the first edge after reset or carrier loss only starts the counters
    armed_d = tmo_hit ? 1'b0 : (edge_det ? 1'b1 : armed_q);

    // stage boundary: symbol result registered one cycle after edge detect
    sym_valid_d  = edge_det & armed_q;
    sym_class_d  = classify(period_q, high_q);
    sym_period_d = period_q;
    first_edge_d = edge_det & ~armed_q;
    timeout_d    = tmo_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0_q      <= 1'b0;
      rx_p1_q      <= 1'b0;
      rx_p2_q      <= 1'b0;
      period_q     <= '0;
      high_q       <= '0;
      idle_q       <= '0;
      armed_q      <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_class_q  <= SYM_INV;
      sym_period_q <= '0;
      first_edge_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      rx_p0_q      <= rx_p0_d;
      rx_p1_q      <= rx_p1_d;
      rx_p2_q      <= rx_p2_d;
      period_q     <= period_d;
      high_q       <= high_d;
      idle_q       <= idle_d;
      armed_q      <= armed_d;
      sym_valid_q  <= sym_valid_d;
      sym_class_q  <= sym_class_d;
      sym_period_q <= sym_period_d;
      first_edge_q <= first_edge_d;
      timeout_q    <= timeout_d;
    end
  end

  assign sym_valid  = sym_valid_q;
  assign sym_class  = sym_class_q;
  assign sym_period = sym_period_q;
  assign first_edge = first_edge_q;
  assign timeout    = timeout_q;

endmodule

// File: rtl/swipt_demod.sv
// SWIPT in-band data demodulator (top).
// Decodes frames of SYNC_LONG+ LONG symbols, a SHORT start symbol, 8 data
// bits LSB-first (SHORT=1, LONG=0), one even-parity bit and a LONG stop.
//   clk, rst : 50 MHz clock, asynchronous active-high reset
//   bus      : swipt_demod_if master (rx_in in; byte, pulses, carrier_ok,
//              period_out out)
// Result pulses appear two cycles after the edge-detect cycle of the
// rising edge that terminates the stop symbol.
module swipt_demod
  import swipt_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int SYNC_LONG   = SYNC_LONG_DEF
) (
  input  logic          clk,
  input  logic          rst,
  swipt_demod_if.master bus
);

  localparam logic [7:0] SYNC_L8 = 8'(SYNC_LONG);

  logic             sym_valid;
  sym_t             sym_class;
  logic [CNT_W-1:0] sym_period;
  logic             first_edge;
  logic             timeout;

  state_t           state_q, state_d;
  logic [7:0]       long_q, long_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sreg_q, sreg_d;
  logic             par_bad_q, par_bad_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             dv_q, dv_d;
  logic             pe_q, pe_d;
  logic             se_q, se_d;

  swipt_sym_meter #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (bus.rx_in),
    .sym_valid  (sym_valid),
    .sym_class  (sym_class),
    .sym_period (sym_period),
    .first_edge (first_edge),
    .timeout    (timeout)
  );

  always_comb begin
    state_d   = state_q;
    long_d    = long_q;
    bit_d     = bit_q;
    sreg_d    = sreg_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    period_d  = period_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (sym_valid && sym_class != SYM_INV)
      period_d = sym_period;

    // carrier loss overrides everything and aborts silently
    if (timeout) begin
      state_d = NOCARRIER;
      long_d  = '0;
    end else begin
      case (state_q)
        NOCARRIER: begin
          if (first_edge) begin
            state_d = IDLE;
            long_d  = '0;
          end
        end
        IDLE: begin
          if (sym_valid) begin
            case (sym_class)
              SYM_LONG: begin
                if (long_q < SYNC_L8) long_d = long_q + 8'd1;
              end
              SYM_SHORT: begin
                if (long_q >= SYNC_L8) begin
                  state_d = DATA;
                  bit_d   = '0;
                end
                long_d = '0;
              end
              default: long_d = '0;
            endcase
          end
        end
        DATA: begin
          if (sym_valid) begin
            if (sym_class == SYM_INV) begin
              se_d    = 1'b1;
              state_d = IDLE;
              long_d  = '0;
            end else begin
              sreg_d = {sym_class == SYM_SHORT, sreg_q[7:1]};
              bit_d  = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (sym_valid) begin
            if (sym_class == SYM_INV) begin
              se_d    = 1'b1;
              state_d = IDLE;
              long_d  = '0;
            end else begin
              // even parity: data bits plus parity bit must XOR to zero
              par_bad_d = (^sreg_q) ^ (sym_class == SYM_SHORT);
              state_d   = STOP;
            end
          end
        end
        STOP: begin
          if (sym_valid) begin
            if (sym_class == SYM_LONG) begin
              if (par_bad_q) begin
                pe_d = 1'b1;
              end else begin
                dv_d   = 1'b1;
                data_d = sreg_q;
              end
            end else begin
              se_d = 1'b1;
            end
            state_d = IDLE;
            long_d  = '0;
          end
        end
        default: state_d = NOCARRIER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NOCARRIER;
      long_q    <= '0;
      bit_q     <= '0;
      sreg_q    <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      period_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      long_q    <= long_d;
      bit_q     <= bit_d;
      sreg_q    <= sreg_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      period_q  <= period_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = dv_q;
  assign bus.parity_err = pe_q;
  assign bus.sym_err    = se_q;
  assign bus.carrier_ok = (state_q != NOCARRIER);
  assign bus.period_out = period_q;

endmodule

// File: tb/tb_swipt_demod.sv
// Bench for swipt_demod: symbol-level reference model feeding a scoreboard,
// with a monitor that checks every result pulse, its cycle and its data.
module tb_swipt_demod;

  localparam int MIN_P   = 250;
  localparam int SYNC_N  = 4;
  localparam int K_VALID = 0;
  localparam int K_PERR  = 1;
  localparam int K_SERR  = 2;
  localparam int C_LONG  = 0;
  localparam int C_SHORT = 1;
  localparam int C_INV   = 2;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  longint cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  swipt_demod_if bus();

  swipt_demod dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    logic [12:0] period;
    longint      at;
  } exp_t;

  exp_t expq[$];

  // reference model state
  bit         m_armed;
  bit         m_in_frame;
  int         m_long;
  bit         m_bits[$];
  logic [7:0] m_data;
  int         m_period;
  int         ph, pp;
  bit         btog;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  function automatic int classify(input int h, input int p);
    if (p >= 8191 || h >= 8191 || 8 * h < p || p < MIN_P) return C_INV;
    if (8 * h >= 3 * p) return C_LONG;
    return C_SHORT;
  endfunction

  function automatic void push_exp(input int k, input longint at);
    exp_t e;
    e.kind   = k;
    e.data   = m_data;
    e.period = 13'(m_period);
    e.at     = at;
    expq.push_back(e);
  endfunction

  function automatic void m_reset();
    m_armed    = 0;
    m_in_frame = 0;
    m_long     = 0;
    m_data     = 8'h00;
    m_period   = 0;
  endfunction

  function automatic void m_lost();
    m_armed    = 0;
    m_in_frame = 0;
    m_long     = 0;
  endfunction

  // One completed symbol applied to the frame rules.
  function automatic void m_step(input int cls, input int p, input longint at);
    logic [7:0] b;
    int ones;
    if (cls != C_INV) m_period = p;
    if (!m_in_frame) begin
      if (cls == C_LONG) m_long++;
      else begin
        if (cls == C_SHORT && m_long >= SYNC_N) begin
          m_in_frame = 1;
          m_bits.delete();
        end
        m_long = 0;
      end
    end else if (cls == C_INV || (m_bits.size() == 9 && cls == C_SHORT)) begin
      push_exp(K_SERR, at);
      m_in_frame = 0;
      m_long     = 0;
    end else if (m_bits.size() < 9) begin
      m_bits.push_back(cls == C_SHORT);
    end else begin
      b    = 8'h00;
      ones = 0;
      for (int i = 0; i < 8; i++) b[i] = m_bits[i];
      for (int i = 0; i < 9; i++) ones += int'(m_bits[i]);
      if (ones % 2 == 0) begin
        m_data = b;
        push_exp(K_VALID, at);
      end else begin
        push_exp(K_PERR, at);
      end
      m_in_frame = 0;
      m_long     = 0;
    end
  endfunction

  // Rising edge at a negedge, high for h cycles, next edge p cycles later.
  // Result of the symbol ended by this edge is due 4 cycles on.
  task automatic send_sym(input int h, input int p);
    @(negedge clk);
    bus.rx_in = 1'b1;
    if (!m_armed) m_armed = 1;
    else m_step(classify(ph, pp), pp, cyc + 4);
    ph = h;
    pp = p;
    repeat (h) @(negedge clk);
    bus.rx_in = 1'b0;
    repeat (p - h - 1) @(negedge clk);
  endtask

  task automatic pick(input int cls, input int mode, output int h, output int p);
    if (mode == 1) begin
      p = 1250;
      h = (cls == C_LONG) ? 600 : 250;
    end else if (mode == 2) begin
      if (cls == C_LONG) begin
        if (btog) begin h = 96; p = 256; end
        else      begin h = 94; p = 250; end
        btog = !btog;
      end else begin
        h = 32; p = 256;
      end
    end else begin
      p = int'($urandom_range(300, 250));
      if (cls == C_LONG) h = int'($urandom_range(p - 2, (3 * p + 7) / 8));
      else               h = int'($urandom_range((3 * p - 1) / 8, (p + 7) / 8));
    end
  endtask

  task automatic send_cls(input int cls, input int mode);
    int h, p;
    pick(cls, mode, h, p);
    send_sym(h, p);
  endtask

  // flaw: 0 none, 1 wrong parity, 2 SHORT stop; nbits < 8 stops mid-byte
  task automatic send_frame(input logic [7:0] b, input int nlong, input int flaw,
                            input int mode, input int nbits);
    for (int i = 0; i < nlong; i++) send_cls(C_LONG, mode);
    send_cls(C_SHORT, mode);
    for (int i = 0; i < nbits; i++) send_cls(b[i] ? C_SHORT : C_LONG, mode);
    if (nbits == 8) begin
      send_cls(((^b) ^ (flaw == 1)) ? C_SHORT : C_LONG, mode);
      send_cls((flaw == 2) ? C_SHORT : C_LONG, mode);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out"},   32'(bus.data_out),   32'h0);
    chk({tag, "_period_out"}, 32'(bus.period_out), 32'h0);
    chk({tag, "_carrier_ok"}, 32'(bus.carrier_ok), 32'h0);
    chk({tag, "_pulses"}, 32'({bus.data_valid, bus.parity_err, bus.sym_err}), 32'h0);
  endtask

  function automatic logic [2:0] kmask(input int k);
    if (k == K_VALID) return 3'b100;
    if (k == K_PERR)  return 3'b010;
    return 3'b001;
  endfunction

  // monitor
  logic [2:0] mon_pul;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_pul = {bus.data_valid, bus.parity_err, bus.sym_err};
      if (expq.size() != 0 && expq[0].at == cyc) begin
        mon_e = expq.pop_front();
        chk("pulse_kind", 32'(mon_pul), 32'(kmask(mon_e.kind)));
        chk("data_out", 32'(bus.data_out), 32'(mon_e.data));
        if (mon_e.kind == K_VALID)
          chk("period_out", 32'(bus.period_out), 32'(mon_e.period));
      end else if (mon_pul != 3'b000) begin
        chk("spurious_pulse", 32'(mon_pul), 32'h0);
      end
    end
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted with %0d results pending", expq.size());
    $fatal(1, "bench did not complete");
  end

  initial begin
    bus.rx_in = 1'b0;
    rst       = 1'b1;
    btog      = 0;
    ph        = 0;
    pp        = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // nominal frame at 1250-cycle symbols
    send_frame(8'hA5, 5, 0, 1, 8);
    // same byte, parity wrong
    send_frame(8'hA5, 5, 1, 0, 8);
    chk("carrier_ok_run", 32'(bus.carrier_ok), 32'(m_armed));
    // too few LONG symbols before the start symbol
    send_frame(8'hFF, 2, 0, 0, 8);
    // invalid symbol as third data bit, then a clean frame
    send_frame(8'h3C, 5, 0, 0, 2);
    send_sym(100, 1250);
    send_frame(8'h3C, 5, 0, 0, 8);
    chk("carrier_ok_after_err", 32'(bus.carrier_ok), 32'(m_armed));

    // carrier loss mid-frame, then restart with 4 LONG symbols
    send_frame(8'($urandom), 5, 0, 0, 3);
    chk("carrier_ok_pre_loss", 32'(bus.carrier_ok), 32'(m_armed));
    bus.rx_in = 1'b0;
    repeat (4150) @(negedge clk);
    m_lost();
    chk("carrier_ok_lost", 32'(bus.carrier_ok), 32'(m_armed));
    send_frame(8'h01, 4, 0, 0, 8);

    // reset while bit 5 is in flight
    send_frame(8'($urandom), 5, 0, 0, 6);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b0;
    send_frame(8'h5A, 5, 0, 0, 8);

    // exact class boundaries: 8h==3p, 8h==p, p==MIN_PERIOD
    send_frame(8'h96, 4, 0, 2, 8);
    // period one below the minimum inside a frame
    send_frame(8'h00, 5, 0, 2, 1);
    send_sym(200, 249);

    // random byte, random sync length; then a SHORT stop symbol
    send_frame(8'($urandom), SYNC_N + int'($urandom_range(2, 0)), 0, 0, 8);
    send_frame(8'($urandom), 5, 2, 0, 8);

    // final edge closes the last stop symbol
    send_cls(C_LONG, 0);
    repeat (8) @(negedge clk);
    chk("scoreboard_drain", 32'(expq.size()), 32'h0);
    chk("carrier_ok_end", 32'(bus.carrier_ok), 32'(m_armed));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
